// File: rtl/cnn_frame_host_if.sv
// Pixel-stream and result handshakes between the frame host and its source/consumer.
interface cnn_frame_host_if #(
   parameter int unsigned PIX_W = 8
);
   logic             PIX_VALID;
   logic [PIX_W-1:0] PIX_DATA;
   logic             PIX_READY;
   logic             RES_VALID;
   logic             RES_READY;
   logic [3:0]       RES_CLASS;
   logic             RES_ERR;

   // Source/consumer side: pushes pixels, takes results.
   modport master (
      output PIX_VALID, PIX_DATA, RES_READY,
      input  PIX_READY, RES_VALID, RES_CLASS, RES_ERR
   );

   // Frame host side: accepts pixels, returns results.
   modport slave (
      input  PIX_VALID, PIX_DATA, RES_READY,
      output PIX_READY, RES_VALID, RES_CLASS, RES_ERR
   );
endinterface

// File: rtl/cnn_frame_host.sv
// Host-side controller for the 5x5 classifier: packs a raster pixel stream into
// the image bus, kicks the classifier, waits for DONE (with timeout) and returns
// the class over a valid/ready result port.
module cnn_frame_host #(
   parameter int unsigned PIX_W   = 8,
   parameter int unsigned N_PIX   = 25,
   parameter int unsigned TIMEOUT = 2048
) (
   input  logic                   CLK,
   input  logic                   nRST,
   cnn_frame_host_if.slave        host,
   output logic [N_PIX*PIX_W-1:0] IMGOUT,
   output logic                   START,
   input  logic                   DONE,
   input  logic [3:0]             OUT,
   output logic                   BUSY
);
   localparam int unsigned IMG_W  = N_PIX * PIX_W;
   localparam int unsigned CNT_W  = 5;
   localparam int unsigned WAIT_W = $clog2(TIMEOUT);

   typedef enum logic [1:0] {
      ST_LOAD   = 2'd0,
      ST_KICK   = 2'd1,
      ST_WAIT   = 2'd2,
      ST_RESULT = 2'd3
   } state_t;

   state_t            state_q,     state_d;
   logic [CNT_W-1:0]  pix_cnt_q,   pix_cnt_d;
   logic [WAIT_W-1:0] wait_cnt_q,  wait_cnt_d;
   logic [IMG_W-1:0]  img_q,       img_d;
   logic              done_q;
   logic              pix_ready_q, pix_ready_d;
   logic              start_q,     start_d;
   logic              busy_q,      busy_d;
   logic              res_valid_q, res_valid_d;
   logic [3:0]        res_class_q, res_class_d;
   logic              res_err_q,   res_err_d;

   logic pix_accept;
   logic done_rise;

   assign pix_accept = host.PIX_VALID && pix_ready_q;
   assign done_rise  = DONE && !done_q;

   // State register and registered outputs; synchronous reset discards any partial frame.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q     <= ST_LOAD;
         pix_cnt_q   <= '0;
         wait_cnt_q  <= '0;
         img_q       <= '0;
         done_q      <= 1'b0;
         pix_ready_q <= 1'b1;
         start_q     <= 1'b0;
         busy_q      <= 1'b0;
         res_valid_q <= 1'b0;
         res_class_q <= '0;
         res_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         pix_cnt_q   <= pix_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
         img_q       <= img_d;
         done_q      <= DONE;
         pix_ready_q <= pix_ready_d;
         start_q     <= start_d;
         busy_q      <= busy_d;
         res_valid_q <= res_valid_d;
         res_class_q <= res_class_d;
         res_err_q   <= res_err_d;
      end
   end

   // Next-state logic; outputs are decoded from the next state so they are registered.
   always_comb begin
      state_d     = state_q;
      pix_cnt_d   = pix_cnt_q;
      wait_cnt_d  = wait_cnt_q;
      img_d       = img_q;
      res_class_d = res_class_q;
      res_err_d   = res_err_q;

      case (state_q)
         ST_LOAD: begin
            if (pix_accept) begin
               for (int unsigned p = 0; p < N_PIX; p++) begin
                  if (pix_cnt_q == CNT_W'(p)) begin
                     img_d[p*PIX_W +: PIX_W] = host.PIX_DATA;
                  end
               end
               if (pix_cnt_q == CNT_W'(N_PIX - 1)) begin
                  pix_cnt_d = '0;
                  state_d   = ST_KICK;
               end else begin
                  pix_cnt_d = pix_cnt_q + CNT_W'(1);
               end
            end
         end
         ST_KICK: begin
            wait_cnt_d = '0;
            state_d    = ST_WAIT;
         end
         ST_WAIT: begin
            // A DONE rise wins over a timeout landing in the same cycle.
            if (done_rise) begin
               res_class_d = OUT;
               res_err_d   = 1'b0;
               state_d     = ST_RESULT;
            end else if (wait_cnt_q == WAIT_W'(TIMEOUT - 1)) begin
               res_class_d = '0;
               res_err_d   = 1'b1;
               state_d     = ST_RESULT;
            end else begin
               wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
         end
         ST_RESULT: begin
            if (host.RES_READY) begin
               state_d = ST_LOAD;
            end
         end
         default: begin
            state_d = ST_LOAD;
         end
      endcase

      pix_ready_d = (state_d == ST_LOAD);
      start_d     = (state_d == ST_KICK);
      busy_d      = (state_d == ST_KICK) || (state_d == ST_WAIT);
      res_valid_d = (state_d == ST_RESULT);
   end

   // Output drive.
   assign host.PIX_READY = pix_ready_q;
   assign host.RES_VALID = res_valid_q;
   assign host.RES_CLASS = res_class_q;
   assign host.RES_ERR   = res_err_q;
   assign IMGOUT         = img_q;
   assign START          = start_q;
   assign BUSY           = busy_q;
endmodule

// File: tb/tb_cnn_frame_host.sv
// Directed bench for cnn_frame_host: table of frames plus hand-written sticky-DONE
// and mid-frame reset sequences.
module tb_cnn_frame_host;
   localparam int unsigned PIX_W   = 8;
   localparam int unsigned N_PIX   = 25;
   localparam int unsigned TIMEOUT = 2048;
   localparam int unsigned IMG_W   = N_PIX * PIX_W;

   logic             CLK = 1'b0;
   logic             nRST;
   logic [IMG_W-1:0] IMGOUT;
   logic             START;
   logic             DONE;
   logic [3:0]       OUT;
   logic             BUSY;

   cnn_frame_host_if #(.PIX_W(PIX_W)) bus ();

   cnn_frame_host #(.PIX_W(PIX_W), .N_PIX(N_PIX), .TIMEOUT(TIMEOUT)) dut (
      .CLK    (CLK),
      .nRST   (nRST),
      .host   (bus),
      .IMGOUT (IMGOUT),
      .START  (START),
      .DONE   (DONE),
      .OUT    (OUT),
      .BUSY   (BUSY)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int passes = 0;
   logic [IMG_W-1:0] exp_img;

   typedef struct {
      logic [7:0] base;
      bit         gaps;
      int         done_at;   // WAIT cycle index at which DONE is raised, -1 = never
      logic [3:0] cls;
      int         hold;      // cycles RES_READY is held low in RESULT
      logic [3:0] exp_cls;
      bit         exp_err;
   } vec_t;

   vec_t vecs[4];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic chk_img(input string name, input logic [IMG_W-1:0] act, input logic [IMG_W-1:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_pix_ready"}, int'(bus.PIX_READY), 1);
      chk({tag, "_start"},     int'(START), 0);
      chk({tag, "_res_valid"}, int'(bus.RES_VALID), 0);
      chk({tag, "_res_class"}, int'(bus.RES_CLASS), 0);
      chk({tag, "_res_err"},   int'(bus.RES_ERR), 0);
      chk({tag, "_busy"},      int'(BUSY), 0);
      chk_img({tag, "_img"}, IMGOUT, '0);
   endtask

   // Streams one full frame; ends at the negedge of the KICK cycle.
   task automatic load_frame(input logic [7:0] base, input bit gaps);
      int bad_start = 0;
      int bad_ready = 0;
      for (int p = 0; p < int'(N_PIX); p++) begin
         if (gaps && ($urandom_range(0, 2) == 0)) begin
            bus.PIX_VALID = 1'b0;
            bus.PIX_DATA  = 8'hEE;
            @(negedge CLK);
            if (START) bad_start++;
            if (!bus.PIX_READY) bad_ready++;
         end
         bus.PIX_VALID = 1'b1;
         bus.PIX_DATA  = base + 8'(p);
         exp_img[p*PIX_W +: PIX_W] = base + 8'(p);
         @(negedge CLK);
         if (p < int'(N_PIX) - 1) begin
            if (START) bad_start++;
            if (!bus.PIX_READY) bad_ready++;
         end
      end
      bus.PIX_VALID = 1'b0;
      chk("load_early_start", bad_start, 0);
      chk("load_pix_ready", bad_ready, 0);
      chk("kick_start", int'(START), 1);
      chk("kick_busy", int'(BUSY), 1);
      chk("kick_pix_ready", int'(bus.PIX_READY), 0);
      chk_img("kick_img", IMGOUT, exp_img);
   endtask

   // Runs WAIT and RESULT, then performs the result handshake.
   task automatic finish_frame(input int done_at, input logic [3:0] cls, input bit keep,
                               input int hold, input logic [3:0] exp_cls, input bit exp_err);
      int k = 0;
      int unstable = 0;
      int exp_lat;
      @(negedge CLK);
      chk("wait_start_low", int'(START), 0);
      chk("wait_busy", int'(BUSY), 1);
      chk("wait_pix_ready", int'(bus.PIX_READY), 0);
      while (!bus.RES_VALID && k < int'(TIMEOUT) + 16) begin
         if (k == done_at) begin
            DONE = 1'b1;
            OUT  = cls;
         end
         @(negedge CLK);
         k++;
      end
      exp_lat = (done_at < 0) ? int'(TIMEOUT) : done_at + 1;
      chk("result_latency", k, exp_lat);
      chk("res_class", int'(bus.RES_CLASS), int'(exp_cls));
      chk("res_err", int'(bus.RES_ERR), int'(exp_err));
      chk("result_busy", int'(BUSY), 0);
      if (!keep) DONE = 1'b0;
      OUT = ~cls;
      if (hold > 0) begin
         bus.PIX_VALID = 1'b1;
         bus.PIX_DATA  = 8'h5A;
      end
      for (int i = 0; i < hold; i++) begin
         @(negedge CLK);
         if (!bus.RES_VALID || bus.RES_CLASS !== exp_cls || bus.RES_ERR !== exp_err || bus.PIX_READY)
            unstable++;
      end
      chk("result_hold_stable", unstable, 0);
      bus.RES_READY = 1'b1;
      @(negedge CLK);
      bus.RES_READY = 1'b0;
      chk("handshake_valid_drop", int'(bus.RES_VALID), 0);
      chk("handshake_pix_ready", int'(bus.PIX_READY), 1);
      chk_img("no_accept_in_result", IMGOUT, exp_img);
      bus.PIX_VALID = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      nRST          = 1'b0;
      bus.PIX_VALID = 1'b0;
      bus.PIX_DATA  = '0;
      bus.RES_READY = 1'b0;
      DONE          = 1'b0;
      OUT           = '0;
      exp_img       = '0;

      vecs[0] = '{base: 8'h01, gaps: 1'b0, done_at: 9,  cls: 4'd7,  hold: 5,  exp_cls: 4'd7,  exp_err: 1'b0};
      vecs[1] = '{base: 8'h40, gaps: 1'b1, done_at: 0,  cls: 4'hA,  hold: 0,  exp_cls: 4'hA,  exp_err: 1'b0};
      vecs[2] = '{base: 8'hC0, gaps: 1'b0, done_at: -1, cls: 4'd5,  hold: 0,  exp_cls: 4'd0,  exp_err: 1'b1};
      vecs[3] = '{base: 8'h10, gaps: 1'b1, done_at: 30, cls: 4'hF,  hold: 20, exp_cls: 4'hF,  exp_err: 1'b0};

      repeat (2) @(negedge CLK);
      check_reset_vals("reset");
      nRST = 1'b1;

      for (int i = 0; i < 4; i++) begin
         load_frame(vecs[i].base, vecs[i].gaps);
         if (i == 0) begin
            chk("img_first_pixel", int'(IMGOUT[7:0]), 1);
            chk("img_last_pixel", int'(IMGOUT[199:192]), 25);
         end
         finish_frame(vecs[i].done_at, vecs[i].cls, 1'b0, vecs[i].hold, vecs[i].exp_cls, vecs[i].exp_err);
      end

      // DONE left high across frames: the second frame sees no rise and times out.
      load_frame(8'h20, 1'b0);
      finish_frame(5, 4'd9, 1'b1, 0, 4'd9, 1'b0);
      load_frame(8'h30, 1'b0);
      finish_frame(-1, 4'd0, 1'b1, 0, 4'd0, 1'b1);
      DONE = 1'b0;
      load_frame(8'h50, 1'b1);
      finish_frame(4, 4'd3, 1'b0, 0, 4'd3, 1'b0);

      // Reset after 12 pixels; the following 25 pixels must form a fresh frame.
      for (int p = 0; p < 12; p++) begin
         bus.PIX_VALID = 1'b1;
         bus.PIX_DATA  = 8'h80 + 8'(p);
         @(negedge CLK);
      end
      nRST          = 1'b0;
      bus.PIX_DATA  = 8'hFF;
      @(negedge CLK);
      bus.PIX_VALID = 1'b0;
      check_reset_vals("midreset");
      nRST    = 1'b1;
      exp_img = '0;
      load_frame(8'h90, 1'b0);
      finish_frame(2, 4'd6, 1'b0, 0, 4'd6, 1'b0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
